// File: rtl/caliptra_ss_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// caliptra_ss_rst_seq_pkg
// Shared types and constants for the Caliptra subsystem reset sequencer.
//   rst_seq_state_e : sequencer FSM states
//   rst_seq_req_e   : reset-service request select (also the request bit index)
//   REQ_PRIO        : arbitration order, highest priority first
//   dly_load_val()  : converts a wait length in cycles to a down-counter preload
// -----------------------------------------------------------------------------
package caliptra_ss_rst_seq_pkg;

   typedef enum logic [2:0] {
      INIT_PG,
      INIT_RST,
      IDLE,
      HALT,
      WAIT_ASSERT,
      WAIT_PG,
      WAIT_RSTB,
      DONE
   } rst_seq_state_e;

   typedef enum logic [1:0] {
      REQ_ASSERT_HARD   = 2'd0,
      REQ_ASSERT        = 2'd1,
      REQ_DEASSERT_HARD = 2'd2,
      REQ_DEASSERT      = 2'd3
   } rst_seq_req_e;

   localparam int unsigned NUM_REQ = 4;

   localparam rst_seq_req_e REQ_PRIO [NUM_REQ] = '{
      REQ_ASSERT_HARD, REQ_ASSERT, REQ_DEASSERT_HARD, REQ_DEASSERT
   };

   // A wait of N cycles spans N-1 decrements after the load cycle; a wait of
   // 0 collapses to the same single cycle as a wait of 1.
   function automatic int unsigned dly_load_val(input int unsigned dly);
      return (dly == 0) ? 0 : dly - 1;
   endfunction

endpackage

// File: rtl/caliptra_ss_rst_seq_dly_cnt.sv
// -----------------------------------------------------------------------------
// caliptra_ss_rst_seq_dly_cnt
// Load/count/expire down-counter shared by every wait state and the halt
// timeout of the reset sequencer.
//   core_clk  in  : clock
//   rst       in  : asynchronous active-high reset (counter takes RST_VAL)
//   load      in  : load load_val this cycle (overrides counting)
//   load_val  in  : preload value
//   expired   out : counter has reached zero
// -----------------------------------------------------------------------------
module caliptra_ss_rst_seq_dly_cnt #(
   parameter int unsigned      CNT_W   = 16,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             core_clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         cnt_q <= RST_VAL;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/caliptra_ss_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// caliptra_ss_rst_seq_ctrl
// Reset sequencer owning cptra_pwrgood / cptra_rst_b. Runs the power-on
// bring-up, then serves four level reset-service requests through a
// fixed-priority arbiter with four-phase done acknowledges.
//
// Optional feature: define CPTRA_SS_RST_SEQ_HALT_EN to park the MCU with a
// halt request/ack handshake (with timeout) before any reset assertion.
// Without it the HALT state is bypassed, mcu_halt_req and halt_timeout_err
// are tied low and mcu_halt_ack is ignored.
//
// Ports:
//   core_clk, rst                 : clock, async active-high reset
//   *_req                         : level reset-service requests
//   *_done                        : four-phase acknowledges
//   cptra_pwrgood, cptra_rst_b    : subsystem power-good / active-low reset
//   mcu_halt_req, mcu_halt_ack    : MCU halt handshake
//   busy                          : FSM not in IDLE
//   halt_timeout_err              : sticky, MCU never acknowledged halt
//   illegal_req_err               : sticky, reset deassert with pwrgood low
// -----------------------------------------------------------------------------
module caliptra_ss_rst_seq_ctrl
   import caliptra_ss_rst_seq_pkg::*;
#(
   parameter int unsigned INIT_PG_DLY  = 20,
   parameter int unsigned INIT_RST_DLY = 120,
   parameter int unsigned ASSERT_DLY   = 100,
   parameter int unsigned DEASSERT_DLY = 100,
   parameter int unsigned HALT_TIMEOUT = 1024,
   parameter int unsigned CNT_W        = 16
) (
   input  logic core_clk,
   input  logic rst,
   input  logic assert_hard_rst_req,
   input  logic deassert_hard_rst_req,
   input  logic assert_rst_req,
   input  logic deassert_rst_req,
   output logic assert_hard_rst_done,
   output logic deassert_hard_rst_done,
   output logic assert_rst_done,
   output logic deassert_rst_done,
   output logic cptra_pwrgood,
   output logic cptra_rst_b,
   output logic mcu_halt_req,
   input  logic mcu_halt_ack,
   output logic busy,
   output logic halt_timeout_err,
   output logic illegal_req_err
);

   localparam logic [CNT_W-1:0] LD_INIT_PG  = CNT_W'(dly_load_val(INIT_PG_DLY));
   localparam logic [CNT_W-1:0] LD_INIT_RST = CNT_W'(dly_load_val(INIT_RST_DLY));
   localparam logic [CNT_W-1:0] LD_ASSERT   = CNT_W'(dly_load_val(ASSERT_DLY));
   localparam logic [CNT_W-1:0] LD_DEASSERT = CNT_W'(dly_load_val(DEASSERT_DLY));

   rst_seq_state_e     state_q, state_d;
   rst_seq_req_e       sel_q, sel_d, grant;
   logic [NUM_REQ-1:0] req_in, req_q, done_q, done_d;
   logic               pg_q, pg_d, rstb_q, rstb_d;
   logic               busy_q, illegal_q, illegal_set;
   logic               cnt_load, cnt_exp;
   logic [CNT_W-1:0]   cnt_val;
   logic               begin_assert, post_halt;

   assign req_in[REQ_ASSERT_HARD]   = assert_hard_rst_req;
   assign req_in[REQ_ASSERT]        = assert_rst_req;
   assign req_in[REQ_DEASSERT_HARD] = deassert_hard_rst_req;
   assign req_in[REQ_DEASSERT]      = deassert_rst_req;

   caliptra_ss_rst_seq_dly_cnt #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_INIT_PG)
   ) u_dly_cnt (
      .core_clk (core_clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .expired  (cnt_exp)
   );

   always_comb begin
      grant = REQ_PRIO[3];
      if      (req_q[REQ_PRIO[0]]) grant = REQ_PRIO[0];
      else if (req_q[REQ_PRIO[1]]) grant = REQ_PRIO[1];
      else if (req_q[REQ_PRIO[2]]) grant = REQ_PRIO[2];
   end

`ifdef CPTRA_SS_RST_SEQ_HALT_EN
   localparam logic [CNT_W-1:0] LD_HALT = CNT_W'(dly_load_val(HALT_TIMEOUT));
   logic ack_q, halt_req_q, timeout_q, timeout_set;
`else
   logic unused_halt_cfg;
   assign unused_halt_cfg = mcu_halt_ack ^ (HALT_TIMEOUT == 0);
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can infer a latch.
      state_d      = state_q;
      sel_d        = sel_q;
      pg_d         = pg_q;
      rstb_d       = rstb_q;
      done_d       = '0;
      cnt_load     = 1'b0;
      cnt_val      = '0;
      illegal_set  = 1'b0;
      begin_assert = 1'b0;
      post_halt    = 1'b0;
`ifdef CPTRA_SS_RST_SEQ_HALT_EN
      timeout_set  = 1'b0;
`endif
      case (state_q)
         INIT_PG: if (cnt_exp) begin
            pg_d     = 1'b1;
            state_d  = INIT_RST;
            cnt_load = 1'b1;
            cnt_val  = LD_INIT_RST;
         end
         INIT_RST: if (cnt_exp) begin
            rstb_d  = 1'b1;
            state_d = IDLE;
         end
         IDLE: if (|req_q) begin
            sel_d = grant;
            unique case (grant)
               REQ_ASSERT_HARD, REQ_ASSERT: begin_assert = 1'b1;
               REQ_DEASSERT_HARD: begin
                  state_d  = WAIT_PG;
                  cnt_load = 1'b1;
                  cnt_val  = LD_DEASSERT;
               end
               REQ_DEASSERT: begin
                  // Releasing reset without power-good is refused but still acknowledged.
                  if (!pg_q) begin
                     state_d     = DONE;
                     illegal_set = 1'b1;
                  end else begin
                     state_d  = WAIT_RSTB;
                     cnt_load = 1'b1;
                     cnt_val  = LD_DEASSERT;
                  end
               end
            endcase
         end
`ifdef CPTRA_SS_RST_SEQ_HALT_EN
         HALT: begin
            if (ack_q) begin
               post_halt = 1'b1;
            end else if (cnt_exp) begin
               post_halt   = 1'b1;
               timeout_set = 1'b1;
            end
         end
`else
         HALT: post_halt = 1'b1;
`endif
         WAIT_ASSERT, WAIT_PG, WAIT_RSTB: begin
            // A hard-reset request aborts any pending wait; the aborted request
            // stays high and is re-arbitrated from scratch later.
            if (req_q[REQ_ASSERT_HARD] && (sel_q != REQ_ASSERT_HARD)) begin
               sel_d        = REQ_ASSERT_HARD;
               begin_assert = 1'b1;
            end else if (cnt_exp) begin
               if (state_q == WAIT_ASSERT) begin
                  rstb_d  = 1'b0;
                  state_d = DONE;
               end else if (state_q == WAIT_PG) begin
                  pg_d     = 1'b1;
                  state_d  = WAIT_RSTB;
                  cnt_load = 1'b1;
                  cnt_val  = LD_DEASSERT;
               end else begin
                  rstb_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (req_q[sel_q]) done_d[sel_q] = 1'b1;
            else              state_d       = IDLE;
         end
         default: state_d = INIT_PG;
      endcase

      if (begin_assert) begin
`ifdef CPTRA_SS_RST_SEQ_HALT_EN
         state_d  = HALT;
         cnt_load = 1'b1;
         cnt_val  = LD_HALT;
`else
         post_halt = 1'b1;
`endif
      end

      if (post_halt) begin
         if (sel_d == REQ_ASSERT_HARD) begin
            pg_d    = 1'b0;
            rstb_d  = 1'b0;
            state_d = DONE;
         end else begin
            state_d  = WAIT_ASSERT;
            cnt_load = 1'b1;
            cnt_val  = LD_ASSERT;
         end
      end
   end

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT_PG;
         sel_q     <= REQ_ASSERT_HARD;
         req_q     <= '0;
         pg_q      <= 1'b0;
         rstb_q    <= 1'b0;
         done_q    <= '0;
         busy_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         req_q     <= req_in;
         pg_q      <= pg_d;
         rstb_q    <= rstb_d;
         done_q    <= done_d;
         busy_q    <= (state_d != IDLE);
         illegal_q <= illegal_q | illegal_set;
      end
   end

`ifdef CPTRA_SS_RST_SEQ_HALT_EN
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         ack_q      <= 1'b0;
         halt_req_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         ack_q      <= mcu_halt_ack;
         halt_req_q <= (state_d == HALT);
         timeout_q  <= timeout_q | timeout_set;
      end
   end

   assign mcu_halt_req     = halt_req_q;
   assign halt_timeout_err = timeout_q;
`else
   assign mcu_halt_req     = 1'b0;
   assign halt_timeout_err = 1'b0;
`endif

   assign assert_hard_rst_done   = done_q[REQ_ASSERT_HARD];
   assign assert_rst_done        = done_q[REQ_ASSERT];
   assign deassert_hard_rst_done = done_q[REQ_DEASSERT_HARD];
   assign deassert_rst_done      = done_q[REQ_DEASSERT];
   assign cptra_pwrgood          = pg_q;
   assign cptra_rst_b            = rstb_q;
   assign busy                   = busy_q;
   assign illegal_req_err        = illegal_q;

endmodule

// File: tb/tb_caliptra_ss_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_caliptra_ss_rst_seq_ctrl
// Directed bench for the reset sequencer with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge. Expectations adapt to
// CPTRA_SS_RST_SEQ_HALT_EN (halt handshake present or bypassed).
// -----------------------------------------------------------------------------
module tb_caliptra_ss_rst_seq_ctrl;

`ifdef CPTRA_SS_RST_SEQ_HALT_EN
   localparam logic HALT_ON = 1'b1;
`else
   localparam logic HALT_ON = 1'b0;
`endif

   logic core_clk, rst;
   logic assert_hard_rst_req, deassert_hard_rst_req, assert_rst_req, deassert_rst_req;
   logic assert_hard_rst_done, deassert_hard_rst_done, assert_rst_done, deassert_rst_done;
   logic cptra_pwrgood, cptra_rst_b, mcu_halt_req, mcu_halt_ack;
   logic busy, halt_timeout_err, illegal_req_err;

   int vectors     = 0;
   int miscompares = 0;

   caliptra_ss_rst_seq_ctrl dut (
      .core_clk               (core_clk),
      .rst                    (rst),
      .assert_hard_rst_req    (assert_hard_rst_req),
      .deassert_hard_rst_req  (deassert_hard_rst_req),
      .assert_rst_req         (assert_rst_req),
      .deassert_rst_req       (deassert_rst_req),
      .assert_hard_rst_done   (assert_hard_rst_done),
      .deassert_hard_rst_done (deassert_hard_rst_done),
      .assert_rst_done        (assert_rst_done),
      .deassert_rst_done      (deassert_rst_done),
      .cptra_pwrgood          (cptra_pwrgood),
      .cptra_rst_b            (cptra_rst_b),
      .mcu_halt_req           (mcu_halt_req),
      .mcu_halt_ack           (mcu_halt_ack),
      .busy                   (busy),
      .halt_timeout_err       (halt_timeout_err),
      .illegal_req_err        (illegal_req_err)
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge core_clk);
   endtask

   // Called on the falling edge after the edge that leaves IDLE (or preempts)
   // toward an assertion; returns on the falling edge after HALT is left.
   task automatic halt_phase(input bit timeout);
`ifdef CPTRA_SS_RST_SEQ_HALT_EN
      vectors++; if (mcu_halt_req !== 1'b1) begin miscompares++; $display("FAIL halt_req_rise: got %b want 1", mcu_halt_req); end
      if (timeout) begin
         cyc(1023);
         vectors++; if (mcu_halt_req !== 1'b1 || halt_timeout_err !== 1'b0) begin miscompares++; $display("FAIL halt_pre_timeout: req=%b err=%b want 1/0", mcu_halt_req, halt_timeout_err); end
         cyc(1);
         vectors++; if (mcu_halt_req !== 1'b0 || halt_timeout_err !== 1'b1) begin miscompares++; $display("FAIL halt_timeout: req=%b err=%b want 0/1", mcu_halt_req, halt_timeout_err); end
      end else begin
         cyc(3);
         mcu_halt_ack = 1'b1;
         cyc(1);
         vectors++; if (mcu_halt_req !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got %b want 1", mcu_halt_req); end
         cyc(1);
         vectors++; if (mcu_halt_req !== 1'b0) begin miscompares++; $display("FAIL halt_exit: got %b want 0", mcu_halt_req); end
         mcu_halt_ack = 1'b0;
      end
`else
      vectors++; if (mcu_halt_req !== 1'b0 || halt_timeout_err !== 1'b0) begin miscompares++; $display("FAIL halt_bypass (timeout case %0d): req=%b err=%b want 0/0", timeout, mcu_halt_req, halt_timeout_err); end
`endif
   endtask

   task automatic hard_assert();
      assert_hard_rst_req = 1'b1;
      cyc(2);
      halt_phase(1'b0);
      vectors++; if ({cptra_pwrgood, cptra_rst_b} !== 2'b00) begin miscompares++; $display("FAIL hard_assert_pins: pg/rstb=%b%b want 00", cptra_pwrgood, cptra_rst_b); end
      cyc(1);
      vectors++; if (assert_hard_rst_done !== 1'b1) begin miscompares++; $display("FAIL hard_assert_done: got %b want 1", assert_hard_rst_done); end
      assert_hard_rst_req = 1'b0;
      cyc(2);
      vectors++; if (assert_hard_rst_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL hard_assert_release: done=%b busy=%b want 0/0", assert_hard_rst_done, busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      assert_hard_rst_req = 1'b0; deassert_hard_rst_req = 1'b0;
      assert_rst_req = 1'b0; deassert_rst_req = 1'b0; mcu_halt_ack = 1'b0;
      cyc(2);
      vectors++; if ({cptra_pwrgood, cptra_rst_b, mcu_halt_req, busy, halt_timeout_err, illegal_req_err} !== 6'b000100) begin miscompares++; $display("FAIL reset_outputs: pg,rstb,halt,busy,terr,ierr=%b%b%b%b%b%b want 000100", cptra_pwrgood, cptra_rst_b, mcu_halt_req, busy, halt_timeout_err, illegal_req_err); end
      vectors++; if ({assert_hard_rst_done, deassert_hard_rst_done, assert_rst_done, deassert_rst_done} !== 4'b0000) begin miscompares++; $display("FAIL reset_done: got %b%b%b%b want 0000", assert_hard_rst_done, deassert_hard_rst_done, assert_rst_done, deassert_rst_done); end
      rst = 1'b0;
      cyc(19);
      vectors++; if (cptra_pwrgood !== 1'b0) begin miscompares++; $display("FAIL init_pg_early: got %b want 0", cptra_pwrgood); end
      cyc(1);
      vectors++; if (cptra_pwrgood !== 1'b1 || cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL init_pg_rise: pg/rstb=%b%b want 10", cptra_pwrgood, cptra_rst_b); end
      cyc(119);
      vectors++; if (cptra_rst_b !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL init_rstb_early: rstb=%b busy=%b want 0/1", cptra_rst_b, busy); end
      cyc(1);
      vectors++; if (cptra_rst_b !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL init_rstb_rise: rstb=%b busy=%b want 1/0", cptra_rst_b, busy); end
   endtask

   task automatic test_assert_rst();
      assert_rst_req = 1'b1;
      cyc(2);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL assert_busy: got %b want 1", busy); end
      halt_phase(1'b0);
      cyc(99);
      vectors++; if (cptra_rst_b !== 1'b1) begin miscompares++; $display("FAIL assert_rstb_early: got %b want 1", cptra_rst_b); end
      cyc(1);
      vectors++; if ({cptra_pwrgood, cptra_rst_b, assert_rst_done} !== 3'b100) begin miscompares++; $display("FAIL assert_rstb_fall: pg,rstb,done=%b%b%b want 100", cptra_pwrgood, cptra_rst_b, assert_rst_done); end
      cyc(1);
      vectors++; if (assert_rst_done !== 1'b1) begin miscompares++; $display("FAIL assert_done_rise: got %b want 1", assert_rst_done); end
      cyc(5);
      vectors++; if (assert_rst_done !== 1'b1) begin miscompares++; $display("FAIL assert_done_hold: got %b want 1", assert_rst_done); end
      assert_rst_req = 1'b0;
      cyc(1);
      vectors++; if (assert_rst_done !== 1'b1) begin miscompares++; $display("FAIL assert_done_sample: got %b want 1", assert_rst_done); end
      cyc(1);
      vectors++; if (assert_rst_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL assert_done_clear: done=%b busy=%b want 0/0", assert_rst_done, busy); end
   endtask

   task automatic test_hard_cycle();
      hard_assert();
      deassert_hard_rst_req = 1'b1;
      cyc(101);
      vectors++; if (cptra_pwrgood !== 1'b0 || mcu_halt_req !== 1'b0) begin miscompares++; $display("FAIL deassert_pg_early: pg=%b halt=%b want 0/0", cptra_pwrgood, mcu_halt_req); end
      cyc(1);
      vectors++; if ({cptra_pwrgood, cptra_rst_b} !== 2'b10) begin miscompares++; $display("FAIL deassert_pg_rise: pg/rstb=%b%b want 10", cptra_pwrgood, cptra_rst_b); end
      cyc(99);
      vectors++; if (cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL deassert_rstb_early: got %b want 0", cptra_rst_b); end
      cyc(1);
      vectors++; if (cptra_rst_b !== 1'b1 || deassert_hard_rst_done !== 1'b0) begin miscompares++; $display("FAIL deassert_rstb_rise: rstb=%b done=%b want 1/0", cptra_rst_b, deassert_hard_rst_done); end
      cyc(1);
      vectors++; if (deassert_hard_rst_done !== 1'b1) begin miscompares++; $display("FAIL deassert_done: got %b want 1", deassert_hard_rst_done); end
      deassert_hard_rst_req = 1'b0;
      cyc(2);
      vectors++; if (deassert_hard_rst_done !== 1'b0) begin miscompares++; $display("FAIL deassert_done_clear: got %b want 0", deassert_hard_rst_done); end
   endtask

`ifdef CPTRA_SS_RST_SEQ_HALT_EN
   task automatic test_halt_timeout();
      assert_rst_req = 1'b1;
      cyc(2);
      halt_phase(1'b1);
      cyc(99);
      vectors++; if (cptra_rst_b !== 1'b1) begin miscompares++; $display("FAIL timeout_rstb_early: got %b want 1", cptra_rst_b); end
      cyc(1);
      vectors++; if (cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL timeout_rstb_fall: got %b want 0", cptra_rst_b); end
      cyc(1);
      assert_rst_req = 1'b0;
      cyc(2);
      vectors++; if (assert_rst_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL timeout_release: done=%b busy=%b want 0/0", assert_rst_done, busy); end
   endtask
`endif

   task automatic test_preempt();
      hard_assert();
      deassert_hard_rst_req = 1'b1;
      cyc(51);
      vectors++; if (cptra_pwrgood !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL preempt_mid_wait: pg=%b busy=%b want 0/1", cptra_pwrgood, busy); end
      assert_hard_rst_req = 1'b1;
      cyc(2);
      halt_phase(1'b0);
      vectors++; if ({cptra_pwrgood, cptra_rst_b} !== 2'b00) begin miscompares++; $display("FAIL preempt_pins: pg/rstb=%b%b want 00", cptra_pwrgood, cptra_rst_b); end
      cyc(1);
      vectors++; if ({assert_hard_rst_done, deassert_hard_rst_done} !== 2'b10) begin miscompares++; $display("FAIL preempt_done: hard/deassert=%b%b want 10", assert_hard_rst_done, deassert_hard_rst_done); end
      assert_hard_rst_req = 1'b0;
      cyc(2);
      vectors++; if (assert_hard_rst_done !== 1'b0 || cptra_pwrgood !== 1'b0) begin miscompares++; $display("FAIL preempt_release: done=%b pg=%b want 0/0", assert_hard_rst_done, cptra_pwrgood); end
      cyc(100);
      vectors++; if (cptra_pwrgood !== 1'b0) begin miscompares++; $display("FAIL rerun_pg_early: got %b want 0", cptra_pwrgood); end
      cyc(1);
      vectors++; if (cptra_pwrgood !== 1'b1) begin miscompares++; $display("FAIL rerun_pg_rise: got %b want 1", cptra_pwrgood); end
      cyc(99);
      vectors++; if (cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL rerun_rstb_early: got %b want 0", cptra_rst_b); end
      cyc(1);
      vectors++; if (cptra_rst_b !== 1'b1) begin miscompares++; $display("FAIL rerun_rstb_rise: got %b want 1", cptra_rst_b); end
      cyc(1);
      vectors++; if (deassert_hard_rst_done !== 1'b1) begin miscompares++; $display("FAIL rerun_done: got %b want 1", deassert_hard_rst_done); end
      deassert_hard_rst_req = 1'b0;
      cyc(2);
   endtask

   task automatic test_priority();
      assert_rst_req   = 1'b1;
      deassert_rst_req = 1'b1;
      cyc(2);
      halt_phase(1'b0);
      cyc(99);
      vectors++; if (cptra_rst_b !== 1'b1) begin miscompares++; $display("FAIL prio_rstb_early: got %b want 1", cptra_rst_b); end
      cyc(1);
      vectors++; if (cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL prio_rstb_fall: got %b want 0", cptra_rst_b); end
      cyc(1);
      vectors++; if ({assert_rst_done, deassert_rst_done} !== 2'b10) begin miscompares++; $display("FAIL prio_winner_done: assert/deassert=%b%b want 10", assert_rst_done, deassert_rst_done); end
      assert_rst_req = 1'b0;
      cyc(2);
      vectors++; if ({assert_rst_done, deassert_rst_done, cptra_rst_b} !== 3'b000) begin miscompares++; $display("FAIL prio_handover: done a/d,rstb=%b%b%b want 000", assert_rst_done, deassert_rst_done, cptra_rst_b); end
      cyc(100);
      vectors++; if (cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL deassert_rst_early: got %b want 0", cptra_rst_b); end
      cyc(1);
      vectors++; if (cptra_rst_b !== 1'b1 || cptra_pwrgood !== 1'b1) begin miscompares++; $display("FAIL deassert_rst_rise: rstb=%b pg=%b want 1/1", cptra_rst_b, cptra_pwrgood); end
      cyc(1);
      vectors++; if (deassert_rst_done !== 1'b1 || illegal_req_err !== 1'b0) begin miscompares++; $display("FAIL deassert_rst_done: done=%b ierr=%b want 1/0", deassert_rst_done, illegal_req_err); end
      deassert_rst_req = 1'b0;
      cyc(2);
   endtask

   task automatic test_illegal();
      hard_assert();
      deassert_rst_req = 1'b1;
      cyc(2);
      vectors++; if ({illegal_req_err, cptra_rst_b, cptra_pwrgood} !== 3'b100) begin miscompares++; $display("FAIL illegal_flag: ierr,rstb,pg=%b%b%b want 100", illegal_req_err, cptra_rst_b, cptra_pwrgood); end
      cyc(1);
      vectors++; if (deassert_rst_done !== 1'b1) begin miscompares++; $display("FAIL illegal_done: got %b want 1", deassert_rst_done); end
      deassert_rst_req = 1'b0;
      cyc(2);
      vectors++; if (deassert_rst_done !== 1'b0 || illegal_req_err !== 1'b1 || cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL illegal_sticky: done=%b ierr=%b rstb=%b want 0/1/0", deassert_rst_done, illegal_req_err, cptra_rst_b); end
   endtask

   task automatic test_async_reset();
      vectors++; if (halt_timeout_err !== HALT_ON) begin miscompares++; $display("FAIL timeout_sticky: got %b want %b", halt_timeout_err, HALT_ON); end
      rst = 1'b1;
      #2;
      vectors++; if ({cptra_pwrgood, cptra_rst_b, busy, halt_timeout_err, illegal_req_err} !== 5'b00100) begin miscompares++; $display("FAIL async_reset: pg,rstb,busy,terr,ierr=%b%b%b%b%b want 00100", cptra_pwrgood, cptra_rst_b, busy, halt_timeout_err, illegal_req_err); end
      cyc(2);
      rst = 1'b0;
      cyc(20);
      vectors++; if (cptra_pwrgood !== 1'b1 || cptra_rst_b !== 1'b0) begin miscompares++; $display("FAIL reinit_pg: pg/rstb=%b%b want 10", cptra_pwrgood, cptra_rst_b); end
   endtask

   initial begin
      test_reset();
      test_assert_rst();
      test_hard_cycle();
`ifdef CPTRA_SS_RST_SEQ_HALT_EN
      test_halt_timeout();
`endif
      test_preempt();
      test_priority();
      test_illegal();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/caliptra_ss_rst_seq_ctrl.md
# caliptra_ss_rst_seq_ctrl

Synthesizable reset sequencer that owns the Caliptra subsystem power-good (`cptra_pwrgood`) and reset (`cptra_rst_b`) outputs. It runs the power-on bring-up sequence, then services four reset-service requests (assert/deassert hard reset, assert/deassert reset) using a fixed-priority arbiter. Before any reset assertion it parks the MCU with a halt handshake. It sits between the SoC reset-service flags and the subsystem reset pins, replacing ad-hoc delay sequencing.

## Interface
- `INIT_PG_DLY`, 20: cycles from reset release to `cptra_pwrgood` rise.
- `INIT_RST_DLY`, 120: cycles from `cptra_pwrgood` rise to `cptra_rst_b` rise during init.
- `ASSERT_DLY`, 100: cycles from halt completion to `cptra_rst_b` fall, for a reset (non-hard) assertion.
- `DEASSERT_DLY`, 100: per-step delay for deassertion sequences.
- `HALT_TIMEOUT`, 1024: cycles to wait for `mcu_halt_ack`.
- `CNT_W`, 16: delay/timeout counter width. Every delay parameter must be below 2^`CNT_W`.

Ports (`name direction width meaning`):
- `core_clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `assert_hard_rst_req` in 1: level request.
- `deassert_hard_rst_req` in 1: level request.
- `assert_rst_req` in 1: level request.
- `deassert_rst_req` in 1: level request.
- `assert_hard_rst_done`, `deassert_hard_rst_done`, `assert_rst_done`, `deassert_rst_done` out 1 each: four-phase acknowledges.
- `cptra_pwrgood` out 1: power-good.
- `cptra_rst_b` out 1: active-low subsystem reset.
- `mcu_halt_req` out 1: halt request to the MCU.
- `mcu_halt_ack` in 1: MCU halted.
- `busy` out 1: high whenever the FSM is not in `IDLE`.
- `halt_timeout_err` out 1: sticky status bit.
- `illegal_req_err` out 1: sticky status bit.

## Operation
- States: `INIT_PG`, `INIT_RST`, `IDLE`, `HALT`, `WAIT_ASSERT`, `WAIT_PG`, `WAIT_RSTB`, `DONE`.
- Init sequence:
  - `INIT_PG` counts `INIT_PG_DLY`, then sets pwrgood=1.
  - `INIT_RST` counts `INIT_RST_DLY`, then sets rst_b=1 and goes to `IDLE`.
  - Requests are ignored during init; they stay pending.
- Arbitration in `IDLE` uses fixed priority: assert_hard > assert_rst > deassert_hard > deassert_rst. The winner is latched as `sel`.
- Assert_hard path:
  - `HALT`, then pwrgood=0 and rst_b=0 in the same cycle, then `DONE`.
- Assert_rst path:
  - `HALT`, then `WAIT_ASSERT` (counts `ASSERT_DLY`), then rst_b=0, then `DONE`.
  - pwrgood is unchanged.
- Deassert_hard path:
  - `WAIT_PG` (counts `DEASSERT_DLY`), then pwrgood=1.
  - `WAIT_RSTB` (counts `DEASSERT_DLY`), then rst_b=1, then `DONE`.
- Deassert_rst path:
  - If pwrgood=0: go directly to `DONE`, set `illegal_req_err`, leave rst_b unchanged.
  - Otherwise: `WAIT_RSTB`, then rst_b=1, then `DONE`.
- `HALT` state:
  - `mcu_halt_req`=1 until `mcu_halt_ack` is seen or `HALT_TIMEOUT` expires.
  - On timeout, set `halt_timeout_err` and proceed with the sequence anyway.
  - `mcu_halt_req` drops when `HALT` is exited.
- `DONE` state:
  - The done bit for `sel` is held high until the matching request goes low.
  - The done bit then clears on the next edge and the FSM returns to `IDLE`.
- Preemption: `assert_hard_rst_req` rising while in `WAIT_ASSERT`, `WAIT_PG` or `WAIT_RSTB` (`sel` ≠ assert_hard) aborts the current sequence.
  - Outputs keep their current values and the FSM enters `HALT` with `sel`=assert_hard.
  - The aborted request stays pending and restarts from its beginning when it is next selected.
- Sticky error bits clear only on `rst`.
- Asserting `rst` at any point returns the block to `INIT_PG` with all outputs at their reset values.

## Timing
- Reset values: `cptra_pwrgood`=0, `cptra_rst_b`=0, `mcu_halt_req`=0, all done bits 0, `busy`=1, both error bits 0.
- All outputs are registered.
- Every wait state lasts exactly its parameter value in cycles; a parameter of 0 means a single-cycle pass-through.
- A request sampled in `IDLE` at edge T enters its first state at T+1.
- For a no-halt path, the pin change is visible after edge T+1+DLY.
- `mcu_halt_req` rises at T+1. The ack is sampled registered, and the exit from `HALT` occurs on the edge after the ack is sampled.
- The done bit rises on the edge following the final pin change.

## Configuration
- `CPTRA_SS_RST_SEQ_HALT_EN` defined: the `HALT` state and its handshake are present.
- Undefined:
  - `HALT` is bypassed; assertion paths go straight from `IDLE` to their pin change or `WAIT_ASSERT`.
  - `mcu_halt_req` is tied to 0, `mcu_halt_ack` is unused, and `halt_timeout_err` is tied to 0.

## Structure
- Package `caliptra_ss_rst_seq_pkg` holds:
  - the state enum `rst_seq_state_e`;
  - the request-select enum `rst_seq_req_e` (`REQ_ASSERT_HARD`, `REQ_ASSERT`, `REQ_DEASSERT_HARD`, `REQ_DEASSERT`);
  - the priority-order constant.
- Sub-module `caliptra_ss_rst_seq_dly_cnt` implements a load/count/expire down-counter of width `CNT_W`. It is shared by the wait states and the halt timeout.

## Test plan
1. **Default init.** Release `rst` → `cptra_pwrgood` rises at cycle 20, `cptra_rst_b` rises at cycle 140, `busy` falls at 140.
2. **Reset assert with halt.** Drive `assert_rst_req`; ack 3 cycles after `mcu_halt_req` rises → `cptra_rst_b`=0 exactly 100 cycles after `HALT` exits, pwrgood stays 1. `assert_rst_done` holds until the request drops, then clears 1 cycle later.
3. **Hard assert then hard deassert.** Drive `assert_hard_rst_req` → pwrgood and rst_b fall together. Then drive `deassert_hard_rst_req` → pwrgood rises 101 cycles after the request, rst_b rises 100 cycles after that.
4. **Halt timeout.** Drive `assert_rst_req` and never assert the ack → `halt_timeout_err`=1 after 1024 cycles, and rst_b falls 100 cycles later.
5. **Preemption.** Raise `assert_hard_rst_req` 50 cycles into a `deassert_hard` wait → the deassert sequence aborts and pwrgood never rises. After the hard-assert handshake completes, the still-pending deassert_hard sequence reruns in full.
6. **Illegal request.** With pwrgood=0, drive `deassert_rst_req` → `deassert_rst_done`=1, `illegal_req_err`=1, rst_b stays 0.
